// File: rtl/debounce_edge_detect_if.sv
// Signal bundle between raw input lines and the debounce_edge_detect conditioner.
// Ports: d_in (raw lines), cnt_clr (counter clear) flow master->slave;
//        level, rise, fall, edge_any, edge_cnt flow slave->master.
interface debounce_edge_detect_if #(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 8
);
  logic [CHANNELS-1:0]       d_in;
  logic                      cnt_clr;
  logic [CHANNELS-1:0]       level;
  logic [CHANNELS-1:0]       rise;
  logic [CHANNELS-1:0]       fall;
  logic [CHANNELS-1:0]       edge_any;
  logic [CHANNELS*CNT_W-1:0] edge_cnt;

  // master: the side driving raw lines and consuming conditioned outputs
  modport master (
    output d_in, cnt_clr,
    input  level, rise, fall, edge_any, edge_cnt
  );

  // slave: the conditioner itself
  modport slave (
    input  d_in, cnt_clr,
    output level, rise, fall, edge_any, edge_cnt
  );
endinterface

// File: rtl/debounce_edge_detect.sv
// Multi-channel debouncer: 2-flop sync, prescaled sampling into a SAMPLES-deep
// window, hysteretic level, one-clk rise/fall/any-edge pulses per channel.
// Latency: 2 + (SAMPLES-1)*TICK_DIV + 2 .. 2 + SAMPLES*TICK_DIV + 1 clocks; no backpressure.
// Ports: clk, rst (async, active-high), bus (slave modport: d_in, cnt_clr in;
//        level, rise, fall, edge_any, edge_cnt out).
// Optional per-channel saturating rising-edge counters under macro EDGE_COUNT_EN;
// without it edge_cnt is tied to 0 and cnt_clr is ignored.
module debounce_edge_detect #(
  parameter int CHANNELS = 4,
  parameter int SAMPLES  = 10,
  parameter int TICK_DIV = 1,
  parameter int CNT_W    = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  debounce_edge_detect_if.slave  bus
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

  logic [CHANNELS-1:0]              sync1_q, sync2_q;
  logic [PW-1:0]                    presc_q, presc_d;
  logic                             tick;
  logic [CHANNELS-1:0][SAMPLES-1:0] shreg_q, shreg_d;
  logic [CHANNELS-1:0]              level_q, level_d;
  logic [CHANNELS-1:0]              level_prev_q;
  logic [CHANNELS-1:0]              rise;

  // Compare on the counter itself: with TICK_DIV=1 the counter stays at 0
  // and tick is permanently high.
  assign tick = (presc_q == PMAX);

  always_comb begin
    presc_d = tick ? '0 : presc_q + PW'(1);
    shreg_d = shreg_q;
    level_d = level_q;
    for (int c = 0; c < CHANNELS; c++) begin
      if (tick) begin
        shreg_d[c] = {shreg_q[c][SAMPLES-2:0], sync2_q[c]};
      end
      // Level follows the window only when it is unanimous; otherwise hold.
      if (&shreg_q[c]) begin
        level_d[c] = 1'b1;
      end else if (~|shreg_q[c]) begin
        level_d[c] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      presc_q      <= '0;
      shreg_q      <= '0;
      level_q      <= '0;
      level_prev_q <= '0;
    end else begin
      sync1_q      <= bus.d_in;
      sync2_q      <= sync1_q;
      presc_q      <= presc_d;
      shreg_q      <= shreg_d;
      level_q      <= level_d;
      level_prev_q <= level_q;
    end
  end

  // Both level copies clear together on reset, so reset never produces a fall.
  assign rise         = level_q & ~level_prev_q;
  assign bus.rise     = rise;
  assign bus.fall     = ~level_q & level_prev_q;
  assign bus.edge_any = level_q ^ level_prev_q;
  assign bus.level    = level_q;

`ifdef EDGE_COUNT_EN
  logic [CHANNELS-1:0][CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    for (int c = 0; c < CHANNELS; c++) begin
      // Clear takes priority over a coincident rise; counters saturate.
      if (bus.cnt_clr) begin
        cnt_d[c] = '0;
      end else if (rise[c] && !(&cnt_q[c])) begin
        cnt_d[c] = cnt_q[c] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Element 0 of the packed array lands in the low CNT_W bits.
  assign bus.edge_cnt = cnt_q;
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = bus.cnt_clr;
  assign bus.edge_cnt   = '0;
`endif

endmodule

// File: tb/tb_debounce_edge_detect.sv
module tb_debounce_edge_detect;

  localparam int CH = 2;
  localparam int CW = 2;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  debounce_edge_detect_if #(.CHANNELS(CH), .CNT_W(CW)) bus_if ();

  debounce_edge_detect #(
    .CHANNELS(CH), .SAMPLES(4), .TICK_DIV(4), .CNT_W(CW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  int n_assert = 0;
  int n_fail   = 0;

  int rc  [CH];
  int fc  [CH];
  int frr [CH];
  int ffl [CH];
  int ea_bad;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    for (int c = 0; c < CH; c++) begin
      rc[c] = 0; fc[c] = 0; frr[c] = -1; ffl[c] = -1;
    end
    ea_bad = 0;
  endtask

  // Step n falling edges, tallying pulses and first-pulse positions per channel.
  task automatic watch(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      for (int c = 0; c < CH; c++) begin
        if (bus_if.rise[c] === 1'b1) begin
          rc[c]++;
          if (frr[c] < 0) frr[c] = i + 1;
        end
        if (bus_if.fall[c] === 1'b1) begin
          fc[c]++;
          if (ffl[c] < 0) ffl[c] = i + 1;
        end
      end
      if (bus_if.edge_any !== (bus_if.rise | bus_if.fall)) ea_bad++;
      if ((bus_if.rise & bus_if.fall) !== '0) ea_bad++;
    end
  endtask

  initial begin
    bit found;
    rst            = 1'b1;
    bus_if.d_in    = '0;
    bus_if.cnt_clr = 1'b0;
    #1;
    chk("reset level", 32'(bus_if.level), 0);
    chk("reset edge_any", 32'(bus_if.edge_any), 0);
    chk("reset edge_cnt", 32'(bus_if.edge_cnt), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Steady low input
    clear_stats();
    watch(50);
    chk("steady rise ch0", 32'(rc[0]), 0);
    chk("steady rise ch1", 32'(rc[1]), 0);
    chk("steady fall", 32'(fc[0] + fc[1]), 0);
    chk("steady edge_any", 32'(ea_bad), 0);
    chk("steady level", 32'(bus_if.level), 0);
    chk("steady edge_cnt", 32'(bus_if.edge_cnt), 0);

    // Clean assert on ch0
    clear_stats();
    bus_if.d_in = 2'b01;
    watch(30);
    chk("assert rise count ch0", 32'(rc[0]), 1);
    chk("assert latency max", 32'(frr[0] <= 19), 1);
    chk("assert latency min", 32'(frr[0] >= 16), 1);
    chk("assert level", 32'(bus_if.level), 1);
    chk("assert ch1 quiet", 32'(rc[1] + fc[1] + fc[0]), 0);
    chk("assert edge_any", 32'(ea_bad), 0);

    // Glitch rejection on ch1: 8 clk high / 8 clk low, five times
    clear_stats();
    for (int k = 0; k < 5; k++) begin
      bus_if.d_in[1] = 1'b1;
      watch(8);
      bus_if.d_in[1] = 1'b0;
      watch(8);
    end
    watch(20);
    chk("glitch level", 32'(bus_if.level), 1);
    chk("glitch rise ch1", 32'(rc[1]), 0);
    chk("glitch fall ch1", 32'(fc[1]), 0);
    chk("glitch ch0 quiet", 32'(rc[0] + fc[0]), 0);

    // Release ch0
    clear_stats();
    bus_if.d_in = 2'b00;
    watch(30);
    chk("release fall count", 32'(fc[0]), 1);
    chk("release latency max", 32'(ffl[0] <= 19), 1);
    chk("release no rise", 32'(rc[0] + rc[1] + fc[1]), 0);
    chk("release edge_any", 32'(ea_bad), 0);
    chk("release level", 32'(bus_if.level), 0);

    // Both channels rise together
    clear_stats();
    bus_if.d_in = 2'b11;
    watch(30);
    chk("simul rise ch0", 32'(rc[0]), 1);
    chk("simul rise ch1", 32'(rc[1]), 1);
    chk("simul same clk", 32'(frr[0] == frr[1]), 1);
    chk("simul level", 32'(bus_if.level), 3);

    // Drop ch0 only
    clear_stats();
    bus_if.d_in = 2'b10;
    watch(30);
    chk("drop ch0 fall", 32'(fc[0]), 1);
    chk("drop ch1 fall", 32'(fc[1]), 0);
    chk("drop level", 32'(bus_if.level), 2);

    // Reset mid-debounce with ch1 settled high
    bus_if.d_in = 2'b11;
    watch(10);
    rst = 1'b1;
    #1;
    chk("midrst level", 32'(bus_if.level), 0);
    chk("midrst fall", 32'(bus_if.fall), 0);
    chk("midrst rise", 32'(bus_if.rise), 0);
    chk("midrst edge_any", 32'(bus_if.edge_any), 0);
    chk("midrst edge_cnt", 32'(bus_if.edge_cnt), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    clear_stats();
    watch(30);
    chk("postrst rise ch0", 32'(rc[0]), 1);
    chk("postrst rise ch1", 32'(rc[1]), 1);
    chk("postrst latency", 32'(frr[0] <= 19), 1);
    chk("postrst no fall", 32'(fc[0] + fc[1]), 0);
    chk("postrst level", 32'(bus_if.level), 3);

`ifdef EDGE_COUNT_EN
    bus_if.cnt_clr = 1'b1;
    @(negedge clk);
    bus_if.cnt_clr = 1'b0;
    chk("cnt clear", 32'(bus_if.edge_cnt), 0);
    clear_stats();
    for (int k = 0; k < 5; k++) begin
      bus_if.d_in[0] = 1'b0;
      watch(25);
      bus_if.d_in[0] = 1'b1;
      watch(25);
    end
    chk("cnt rises seen", 32'(rc[0]), 5);
    chk("cnt saturated ch0", 32'(bus_if.edge_cnt[1:0]), 3);
    chk("cnt ch1 idle", 32'(bus_if.edge_cnt[3:2]), 0);
    bus_if.d_in[0] = 1'b0;
    watch(25);
    bus_if.d_in[0] = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (bus_if.rise[0] === 1'b1) begin
        found = 1'b1;
        bus_if.cnt_clr = 1'b1;
        break;
      end
    end
    @(negedge clk);
    bus_if.cnt_clr = 1'b0;
    chk("sixth rise seen", 32'(found), 1);
    chk("clear beats rise", 32'(bus_if.edge_cnt), 0);
`else
    bus_if.cnt_clr = 1'b1;
    bus_if.d_in    = 2'b00;
    clear_stats();
    watch(25);
    bus_if.cnt_clr = 1'b0;
    bus_if.d_in    = 2'b11;
    watch(25);
    chk("nocnt rises", 32'(rc[0] + rc[1]), 2);
    chk("nocnt edge_cnt", 32'(bus_if.edge_cnt), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
